// File: rtl/ex_coproc_sequencer_pkg.sv
// Shared definitions for the execute-stage coprocessor sequencer:
// FSM state encoding, FPU opcode values and the default datapath width.
package ex_coproc_sequencer_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FPU_REQ  = 3'd1;
  localparam logic [2:0] S_FPU_WAIT = 3'd2;
  localparam logic [2:0] S_MM_REQ   = 3'd3;
  localparam logic [2:0] S_MM_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Opcode values as carried in fpu_control_e
  localparam logic [2:0] FPU_ADD = 3'b000;
  localparam logic [2:0] FPU_SUB = 3'b001;
  localparam logic [2:0] FPU_MUL = 3'b010;
  localparam logic [2:0] FPU_DIV = 3'b011;

  function automatic logic is_busy(input logic [2:0] s);
    return (s == S_FPU_REQ) || (s == S_FPU_WAIT) ||
           (s == S_MM_REQ)  || (s == S_MM_WAIT);
  endfunction

endpackage

// File: rtl/ex_coproc_sequencer_timeout.sv
// Wait-state watchdog: counts cycles spent in one handshake state and flags
// expiry once TIMEOUT cycles have elapsed without the state changing.
module cop_timeout_counter
  import ex_coproc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + TO_W'(1);
  end

  assign expired = enable && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/ex_coproc_sequencer.sv
// Execute-stage coprocessor sequencer: launches FPU/matmul ops over req/ack/done,
// stalls the pipeline while outstanding and returns the result to EX/MEM.
//
//   state      | meaning
//   IDLE       | waiting for a start in E
//   FPU_REQ    | fpu_req high, waiting for fpu_ack
//   FPU_WAIT   | FPU accepted, waiting for fpu_done
//   MM_REQ     | mm_req high, waiting for mm_ack
//   MM_WAIT    | matmul accepted, waiting for mm_done
//   DONE       | result presented, held while e_hold
module ex_coproc_sequencer
  import ex_coproc_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fpu_start_e,
  input  logic [2:0]        fpu_control_e,
  input  logic              matmul_start_e,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  logic              flush_e,
  input  logic              e_hold,
  output logic              fpu_req,
  output logic [2:0]        fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic              fpu_ack,
  input  logic              fpu_done,
  input  logic [DATA_W-1:0] fpu_result,
  output logic              mm_req,
  input  logic              mm_ack,
  input  logic              mm_done,
  output logic              stall_cop,
  output logic [DATA_W-1:0] cop_result,
  output logic              cop_valid,
  output logic              cop_err
);

  logic [2:0]        state, next_state;
  logic              squash;
  logic              err_q;
  logic [DATA_W-1:0] result_q;
  logic              busy;
  logic              expired;
  logic              launch;
  logic              complete;
  logic              abort;

  assign busy   = is_busy(state);
  assign launch = (state == S_IDLE) && !flush_e && (fpu_start_e || matmul_start_e);

  assign complete = ((state == S_FPU_REQ)  && fpu_ack && fpu_done) ||
                    ((state == S_FPU_WAIT) && fpu_done) ||
                    ((state == S_MM_REQ)   && mm_ack && mm_done) ||
                    ((state == S_MM_WAIT)  && mm_done);

  assign abort = expired && (next_state == S_DONE) && !complete;

  cop_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (next_state != state),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (!flush_e) begin
          if (fpu_start_e)         next_state = S_FPU_REQ;
          else if (matmul_start_e) next_state = S_MM_REQ;
        end
      end
      S_FPU_REQ: begin
        if (fpu_ack && fpu_done) next_state = S_DONE;
        else if (fpu_ack)        next_state = S_FPU_WAIT;
        else if (expired)        next_state = S_DONE;
      end
      S_FPU_WAIT: begin
        if (fpu_done || expired) next_state = S_DONE;
      end
      S_MM_REQ: begin
        if (mm_ack && mm_done) next_state = S_DONE;
        else if (mm_ack)       next_state = S_MM_WAIT;
        else if (expired)      next_state = S_DONE;
      end
      S_MM_WAIT: begin
        if (mm_done || expired) next_state = S_DONE;
      end
      S_DONE: begin
        if (!e_hold) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operands and opcode are sampled only at launch so they stay stable downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpu_op   <= '0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      squash   <= 1'b0;
    end else begin
      if (launch) begin
        fpu_a    <= src_a_e;
        fpu_b    <= src_b_e;
        result_q <= '0;
        err_q    <= 1'b0;
        if (fpu_start_e)
          fpu_op <= fpu_control_e;
      end
      if (complete && ((state == S_FPU_REQ) || (state == S_FPU_WAIT)))
        result_q <= fpu_result;
      if (abort) begin
        result_q <= '0;
        err_q    <= 1'b1;
      end
      if ((state == S_DONE) && !e_hold)
        squash <= 1'b0;
      else if (busy && flush_e)
        squash <= 1'b1;
    end
  end

  always_comb begin
    fpu_req    = (state == S_FPU_REQ);
    mm_req     = (state == S_MM_REQ);
    stall_cop  = busy || launch;
    cop_valid  = (state == S_DONE) && !squash;
    cop_err    = (state == S_DONE) && !squash && err_q;
    cop_result = result_q;
  end

endmodule

// File: tb/tb_ex_coproc_sequencer.sv
// Directed bench for ex_coproc_sequencer: FPU and matmul handshakes, priority,
// hold in DONE, squash, timeout abort and asynchronous reset mid-operation.
module tb_ex_coproc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fpu_start_e, matmul_start_e, flush_e, e_hold;
  logic [2:0]  fpu_control_e;
  logic [31:0] src_a_e, src_b_e;
  logic        fpu_ack, fpu_done, mm_ack, mm_done;
  logic [31:0] fpu_result;

  logic        fpu_req, mm_req, stall_cop, cop_valid, cop_err;
  logic [2:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, cop_result;

  logic        t_fpu_req, t_mm_req, t_stall, t_valid, t_err;
  logic [2:0]  t_fpu_op;
  logic [31:0] t_fpu_a, t_fpu_b, t_result;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt_a, cnt_b, cnt_c;

  always #5 clk = ~clk;

  ex_coproc_sequencer #(.DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .fpu_start_e(fpu_start_e), .fpu_control_e(fpu_control_e),
    .matmul_start_e(matmul_start_e), .src_a_e(src_a_e), .src_b_e(src_b_e),
    .flush_e(flush_e), .e_hold(e_hold),
    .fpu_req(fpu_req), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ack(fpu_ack), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .mm_req(mm_req), .mm_ack(mm_ack), .mm_done(mm_done),
    .stall_cop(stall_cop), .cop_result(cop_result),
    .cop_valid(cop_valid), .cop_err(cop_err)
  );

  // Short-timeout instance used for the abort scenario
  ex_coproc_sequencer #(.DATA_W(32), .TIMEOUT(8)) dut_to (
    .clk(clk), .reset_n(reset_n),
    .fpu_start_e(fpu_start_e), .fpu_control_e(fpu_control_e),
    .matmul_start_e(matmul_start_e), .src_a_e(src_a_e), .src_b_e(src_b_e),
    .flush_e(flush_e), .e_hold(e_hold),
    .fpu_req(t_fpu_req), .fpu_op(t_fpu_op), .fpu_a(t_fpu_a), .fpu_b(t_fpu_b),
    .fpu_ack(fpu_ack), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .mm_req(t_mm_req), .mm_ack(mm_ack), .mm_done(mm_done),
    .stall_cop(t_stall), .cop_result(t_result),
    .cop_valid(t_valid), .cop_err(t_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fpu_start_e = 0; matmul_start_e = 0; flush_e = 0; e_hold = 0;
    fpu_ack = 0; fpu_done = 0; mm_ack = 0; mm_done = 0;
  endtask

  initial begin
    idle_inputs();
    fpu_control_e = 3'b000; src_a_e = '0; src_b_e = '0; fpu_result = '0;
    reset_n = 0;
    #1;
    chk("rst_fpu_req", {31'b0, fpu_req}, 0);
    chk("rst_mm_req", {31'b0, mm_req}, 0);
    chk("rst_stall", {31'b0, stall_cop}, 0);
    chk("rst_valid", {31'b0, cop_valid}, 0);
    chk("rst_err", {31'b0, cop_err}, 0);
    chk("rst_result", cop_result, 0);
    chk("rst_fpu_a", fpu_a, 0);
    repeat (2) next_cycle();
    reset_n = 1;
    next_cycle();

    // FPU add: ack in cycle 1, done in cycle 4, DONE in cycle 5
    cnt_a = 0;
    for (int c = 0; c <= 6; c++) begin
      fpu_start_e = (c == 0);
      fpu_control_e = 3'b000;
      src_a_e = (c == 0) ? 32'h3F800000 : 32'hFFFFFFFF;
      src_b_e = (c == 0) ? 32'h40000000 : 32'hFFFFFFFF;
      fpu_ack = (c == 1);
      fpu_done = (c == 4);
      fpu_result = (c == 4) ? 32'h40400000 : 32'h0BADF00D;
      @(negedge clk);
      cnt_a += int'(stall_cop);
      if (c == 2) begin
        chk("add_fpu_a", fpu_a, 32'h3F800000);
        chk("add_fpu_b", fpu_b, 32'h40000000);
        chk("add_fpu_op", {29'b0, fpu_op}, 0);
      end
      if (c == 1) chk("add_req_c1", {31'b0, fpu_req}, 1);
      if (c == 2) chk("add_req_c2", {31'b0, fpu_req}, 0);
      if (c == 5) begin
        chk("add_valid", {31'b0, cop_valid}, 1);
        chk("add_result", cop_result, 32'h40400000);
        chk("add_stall_done", {31'b0, stall_cop}, 0);
      end
      if (c == 6) chk("add_valid_clr", {31'b0, cop_valid}, 0);
      next_cycle();
    end
    chk("add_stall_cycles", cnt_a, 5);

    // Matmul: req for 2 cycles, done in cycle 11, DONE in cycle 12
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 13; c++) begin
      matmul_start_e = (c == 0);
      mm_ack = (c == 2);
      mm_done = (c == 11);
      @(negedge clk);
      cnt_a += int'(stall_cop);
      cnt_b += int'(mm_req);
      if (c == 12) begin
        chk("mm_valid", {31'b0, cop_valid}, 1);
        chk("mm_result", cop_result, 0);
        chk("mm_err", {31'b0, cop_err}, 0);
      end
      next_cycle();
    end
    chk("mm_stall_cycles", cnt_a, 12);
    chk("mm_req_cycles", cnt_b, 2);

    // Both starts: FPU wins
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 5; c++) begin
      fpu_start_e = (c == 0);
      matmul_start_e = (c == 0);
      fpu_ack = (c == 1);
      fpu_done = (c == 3);
      fpu_result = 32'h12345678;
      @(negedge clk);
      cnt_a += int'(fpu_req);
      cnt_b += int'(mm_req);
      if (c == 4) chk("both_result", cop_result, 32'h12345678);
      next_cycle();
    end
    chk("both_fpu_req_cycles", cnt_a, 1);
    chk("both_mm_req_cycles", cnt_b, 0);

    // Ack+done together, then DONE held by e_hold in cycles 2..4 with start still high
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c <= 6; c++) begin
      fpu_start_e = (c <= 5);
      fpu_ack = (c == 1);
      fpu_done = (c == 1);
      fpu_result = 32'hCAFE0001;
      e_hold = (c >= 2) && (c <= 4);
      @(negedge clk);
      cnt_a += int'(cop_valid);
      cnt_b += int'(fpu_req);
      if (c == 4) chk("hold_result", cop_result, 32'hCAFE0001);
      if (c == 6) begin
        chk("hold_idle_stall", {31'b0, stall_cop}, 0);
        chk("hold_idle_valid", {31'b0, cop_valid}, 0);
      end
      next_cycle();
    end
    chk("hold_valid_cycles", cnt_a, 4);
    chk("hold_fpu_req_cycles", cnt_b, 1);
    idle_inputs();

    // Flush with a start in IDLE: no launch, no stall
    fpu_start_e = 1; flush_e = 1;
    @(negedge clk);
    chk("flush_idle_stall", {31'b0, stall_cop}, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("flush_idle_noreq", {31'b0, fpu_req}, 0);
    next_cycle();

    // Flush during FPU_WAIT: op completes but result is squashed
    for (int c = 0; c <= 6; c++) begin
      fpu_start_e = (c == 0);
      fpu_ack = (c == 1);
      flush_e = (c == 2);
      fpu_done = (c == 4);
      fpu_result = 32'h55AA55AA;
      @(negedge clk);
      if (c == 4) chk("squash_stall_c4", {31'b0, stall_cop}, 1);
      if (c == 5) begin
        chk("squash_valid", {31'b0, cop_valid}, 0);
        chk("squash_err", {31'b0, cop_err}, 0);
        chk("squash_stall_done", {31'b0, stall_cop}, 0);
      end
      next_cycle();
    end
    idle_inputs();

    // Timeout (TIMEOUT=8 instance): req held 8 cycles, then DONE with error
    reset_n = 0;
    next_cycle();
    reset_n = 1;
    next_cycle();
    cnt_a = 0;
    for (int c = 0; c <= 14; c++) begin
      fpu_start_e = (c == 0);
      src_a_e = 32'h11111111;
      fpu_ack = (c == 10);
      fpu_done = (c == 10);
      fpu_result = 32'hDEADBEEF;
      @(negedge clk);
      cnt_a += int'(t_fpu_req);
      if (c == 8) chk("to_req_c8", {31'b0, t_fpu_req}, 1);
      if (c == 9) begin
        chk("to_req_drop", {31'b0, t_fpu_req}, 0);
        chk("to_valid", {31'b0, t_valid}, 1);
        chk("to_err", {31'b0, t_err}, 1);
        chk("to_result", t_result, 0);
      end
      if (c == 11) begin
        chk("to_late_valid", {31'b0, t_valid}, 0);
        chk("to_late_stall", {31'b0, t_stall}, 0);
        chk("to_late_result", t_result, 0);
      end
      next_cycle();
    end
    chk("to_req_cycles", cnt_a, 8);
    idle_inputs();

    // Reset asserted while in MM_WAIT
    matmul_start_e = 1;
    next_cycle();
    matmul_start_e = 0; mm_ack = 1;
    @(negedge clk);
    chk("rmid_mm_req", {31'b0, mm_req}, 1);
    next_cycle();
    mm_ack = 0;
    next_cycle();
    reset_n = 0;
    #1;
    chk("rmid_stall", {31'b0, stall_cop}, 0);
    chk("rmid_mm_req0", {31'b0, mm_req}, 0);
    chk("rmid_valid", {31'b0, cop_valid}, 0);
    chk("rmid_fpu_a", fpu_a, 0);
    next_cycle();
    reset_n = 1;
    @(negedge clk);
    chk("rmid_idle_stall", {31'b0, stall_cop}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
